div_sqrt_unit: RTL and testbench
================================

# div_sqrt_unit

Parametrised sequential arithmetic unit that performs the lab's three workloads in hardware: fixed-point reciprocal, scaled division and integer square root. Results are rounded half-up and saturate. It sits beside the CPU datapath as a multi-cycle functional unit with the same Start/Ack handshake the CPU exposes to the test bench. Width is set by parameter `W`; the default `W=16` reproduces the program 1/2/3 result formats bit-exactly.

## Interface
- `W`, default 16: operand width; must be even and ≥ 8.
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Mode`  in  2  operation select, captured with Start: 0 RECIP, 1 DIV, 2 SQRT, 3 illegal.
- `OpA`  in  W  operand: RECIP divisor x, DIV dividend A, SQRT operand A.
- `OpB`  in  W/2  DIV divisor B; ignored in other modes.
- `Result`  out  3W/2  rounded result, zero-extended; held until the next accepted Start.
- `Ack`  out  1  one-cycle pulse; Result is valid in this cycle.
- `Busy`  out  1  high from the accepting edge until the edge that drops Ack.
- `Err`  out  1  high with Ack for illegal mode; otherwise 0.

## Operation
- States: IDLE → CALC → ROUND → DONE → IDLE. Operands and Mode are latched on the accepting edge; later input changes are ignored.
- RECIP:
  - Restoring divide Q = floor(2^W / x), W+1 iterations.
  - Result = (Q>>1) + Q[0], saturated to W bits (2^W−1).
  - x=0 → all ones (W bits).
- DIV:
  - Q = floor(A·2^(W/2+1) / B), 3W/2+1 iterations.
  - Result = (Q>>1) + Q[0], saturated to 3W/2 bits.
  - B=0 → all ones (3W/2 bits).
- SQRT:
  - Digit-by-digit, W/2 iterations, giving r = floor(√A) and rem = A − r².
  - Round up iff rem > r. If r is all ones, there is no round-up (saturate at 2^(W/2)−1).
  - A=0 → 0.
- Zero divisor and illegal mode skip CALC and ROUND: IDLE → DONE.
  - Illegal mode: Result = 0, Err = 1.
- One bit per CALC cycle. Iteration counter width is clog2(3W/2+2). Partial remainder widths: W+1 (RECIP), W/2+1 (DIV), W/2+2 (SQRT).
- Unused upper Result bits are 0 for RECIP and SQRT.

## Timing
- Reset low at an edge forces, at that edge:
  - state IDLE
  - Result=0, Ack=0, Busy=0, Err=0
  - counter and remainders cleared
- Reset mid-operation aborts the operation; no Ack is produced.
- Accept: Start=1 in IDLE at edge k. Busy=1 from edge k.
- Normal path:
  - CALC occupies N cycles: N=W+1 (RECIP), 3W/2+1 (DIV), W/2 (SQRT).
  - ROUND takes one cycle.
  - Ack=1 during the cycle after edge k+N+1, i.e. asserted at edge k+N+2 and cleared at the next edge.
- W=16 latencies (accept to Ack): RECIP 19, DIV 27, SQRT 10.
- Shortcut path (zero divisor, illegal mode): Ack asserted at edge k+1.
- Start high while Busy is ignored; there is no queueing.
- Start still high in the cycle after Ack (back in IDLE) begins a new operation on the next edge.
- Result changes only at the ROUND→DONE edge, the shortcut edge, or reset.

## Structure
- Package `div_sqrt_pkg` holds:
  - mode enum (RECIP, DIV, SQRT, ILLEGAL)
  - state enum (IDLE, CALC, ROUND, DONE)
  - constant function for per-mode iteration count N(W)
  - saturation helper
- One natural sub-module: `restore_step`, a combinational trial-subtract returning a ge flag and the new remainder. It is shared by all three modes. Its width is the maximum of the three remainder widths.

## Test plan
- W=16, RECIP, OpA=4 → Result=0x2000, Ack 19 cycles after accept. OpA=3 → 0x2AAB. OpA=1 → 0x8000. OpA=0 → 0xFFFF with Ack at k+1.
- DIV, A=3, B=0xFF → 0x000003. A=0xFFFF, B=1 → 0xFFFF00. A=1, B=3 → 0x000055. B=0 → 0xFFFFFF. Ack 27 cycles after accept.
- SQRT, A=81 → 0x09. A=90 → 0x09. A=91 → 0x0A. A=65535 → 0xFF (saturated). A=0 → 0x00. Ack 10 cycles after accept.
- Mode=3 → Ack at k+1 with Err=1 and Result=0. The next legal op → Err=0.
- Reset low during CALC of a DIV → all outputs 0 next edge, no Ack. Start pulsed while Busy → ignored. Start held through Ack → a second op starts in the cycle after Ack.
- W=24 parameter sweep: 200 random RECIP/DIV/SQRT ops checked against a wide-integer bench model. Latencies must be 27/39/14.

Source files
------------

// File: rtl/div_sqrt_pkg.sv
// div_sqrt_pkg: shared types and helpers for the div/sqrt unit.
// Mode codes, FSM state encoding, iteration counts, saturation.
package div_sqrt_pkg;

   typedef enum logic [1:0] {
      M_RECIP   = 2'd0,
      M_DIV     = 2'd1,
      M_SQRT    = 2'd2,
      M_ILLEGAL = 2'd3
   } mode_e;

   // state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // CALC cycles per mode for operand width w
   function automatic int unsigned iter_count(
      input logic [1:0]  m,
      input int unsigned w
   );
      case (m)
         M_RECIP: return w + 1;
         M_DIV:   return (3 * w) / 2 + 1;
         M_SQRT:  return w / 2;
         default: return 0;
      endcase
   endfunction

   // clamp v to an unsigned field of the given width
   function automatic logic [63:0] sat_to(
      input logic [63:0] v,
      input int unsigned bits
   );
      logic [63:0] lim;
      lim = (64'd1 << bits) - 64'd1;
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/div_sqrt_unit_restore_step.sv
// restore_step: one trial subtraction of a restoring divide/sqrt.
// Ports: rem (shifted partial remainder), sub (trial value) -> ge, new_rem.
module restore_step #(
   parameter int unsigned RW = 17
) (
   input  logic [RW-1:0] rem,
   input  logic [RW-1:0] sub,
   output logic          ge,
   output logic [RW-1:0] new_rem
);

   assign ge      = (rem >= sub);
   assign new_rem = ge ? (rem - sub) : rem;

endmodule

// File: rtl/div_sqrt_unit.sv
// div_sqrt_unit: multi-cycle reciprocal / scaled divide / integer sqrt.
// Ports: Clk, Reset(sync, low), Start, Mode, OpA, OpB -> Result, Ack, Busy, Err.
module div_sqrt_unit
   import div_sqrt_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Mode,
   input  logic [W-1:0]      OpA,
   input  logic [W/2-1:0]    OpB,
   output logic [3*W/2-1:0]  Result,
   output logic              Ack,
   output logic              Busy,
   output logic              Err
);

   localparam int unsigned H   = W / 2;
   localparam int unsigned RSW = 3 * W / 2;
   localparam int unsigned QW  = RSW + 1;
   localparam int unsigned RW  = W + 1;
   localparam int unsigned CW  = $clog2(RSW + 2);

   logic [1:0]     state;
   logic [1:0]     mode_q;
   logic [CW-1:0]  cnt;
   logic [RW-1:0]  rem;
   logic [QW-1:0]  q;
   logic [QW-1:0]  dvd;
   logic [W-1:0]   dsr;
   logic [RSW-1:0] res;

   logic           is_sqrt;
   logic           last;
   logic [RW-1:0]  step_rem;
   logic [RW-1:0]  step_sub;
   logic [RW-1:0]  step_new;
   logic           step_ge;
   logic [QW-1:0]  qs;
   logic [H-1:0]   root;
   logic           up;
   logic [RSW-1:0] round_res;

   assign is_sqrt = (mode_q == M_SQRT);
   assign last    = (cnt == CW'(iter_count(mode_q, W) - 1));

   // sqrt brings down two dividend bits and tries 4r+1;
   // the dividers bring down one bit and try the divisor
   assign step_rem = is_sqrt ? {rem[RW-3:0], dvd[QW-1:QW-2]}
                             : {rem[RW-2:0], dvd[QW-1]};
   assign step_sub = is_sqrt ? {{(RW-H-2){1'b0}}, q[H-1:0], 2'b01}
                             : {1'b0, dsr};

   restore_step #(.RW(RW)) u_step (
      .rem     (step_rem),
      .sub     (step_sub),
      .ge      (step_ge),
      .new_rem (step_new)
   );

   // half-up rounding of the extra quotient bit; sqrt rounds up
   // when rem > r, which is exactly A >= (r + 0.5)^2 in integers
   always_comb begin
      qs        = {1'b0, q[QW-1:1]} + QW'(q[0]);
      root      = q[H-1:0];
      up        = (rem > {{(RW-H){1'b0}}, root}) && !(&root);
      round_res = '0;
      case (mode_q)
         M_RECIP: round_res = RSW'(sat_to(64'(qs), W));
         M_DIV:   round_res = RSW'(sat_to(64'(qs), RSW));
         M_SQRT:  round_res = {{(RSW-H){1'b0}}, root} + RSW'(up);
         default: round_res = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state  <= ST_IDLE;
         mode_q <= '0;
         cnt    <= '0;
         rem    <= '0;
         q      <= '0;
         dvd    <= '0;
         dsr    <= '0;
         res    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (Start) begin
                  mode_q <= Mode;
                  cnt    <= '0;
                  rem    <= '0;
                  q      <= '0;
                  dsr    <= (Mode == M_DIV) ? {{(W-H){1'b0}}, OpB} : OpA;
                  // dividend MSB-aligned: 2^W for recip, A<<(H+1) otherwise
                  dvd    <= (Mode == M_RECIP) ? {1'b1, {(QW-1){1'b0}}}
                                              : {OpA, {(H+1){1'b0}}};
                  if (Mode == M_ILLEGAL) begin
                     res   <= '0;
                     state <= ST_DONE;
                  end else if (Mode == M_RECIP && OpA == '0) begin
                     res   <= {{(RSW-W){1'b0}}, {W{1'b1}}};
                     state <= ST_DONE;
                  end else if (Mode == M_DIV && OpB == '0) begin
                     res   <= '1;
                     state <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               rem   <= step_new;
               q     <= {q[QW-2:0], step_ge};
               dvd   <= is_sqrt ? (dvd << 2) : (dvd << 1);
               cnt   <= cnt + CW'(1);
               if (last)
                  state <= ST_ROUND;
            end
            ST_ROUND: begin
               res   <= round_res;
               state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
         endcase
      end
   end

   assign Result = res;
   assign Ack    = (state == ST_DONE);
   assign Busy   = (state != ST_IDLE);
   assign Err    = Ack && (mode_q == M_ILLEGAL);

endmodule

// File: tb/tb_div_sqrt_unit.sv
// tb_div_sqrt_unit: scoreboard bench, W=16 directed and W=24 random.
// Drivers push expected results; negedge monitors pop on Ack.
module tb_div_sqrt_unit;

   typedef struct {
      logic [63:0] res;
      logic        err;
      int          lat;
      int          k;
   } exp_t;

   logic        clk;
   int          cyc;
   int          total;
   int          bad;

   logic        rst16, start16, ack16, busy16, err16;
   logic [1:0]  mode16;
   logic [15:0] opa16;
   logic [7:0]  opb16;
   logic [23:0] res16;

   logic        rst24, start24, ack24, busy24, err24;
   logic [1:0]  mode24;
   logic [23:0] opa24;
   logic [11:0] opb24;
   logic [35:0] res24;

   exp_t q16[$];
   exp_t q24[$];

   div_sqrt_unit #(.W(16)) dut16 (
      .Clk(clk), .Reset(rst16), .Start(start16), .Mode(mode16),
      .OpA(opa16), .OpB(opb16), .Result(res16), .Ack(ack16),
      .Busy(busy16), .Err(err16)
   );

   div_sqrt_unit #(.W(24)) dut24 (
      .Clk(clk), .Reset(rst24), .Start(start24), .Mode(mode24),
      .OpA(opa24), .OpB(opb24), .Result(res24), .Ack(ack24),
      .Busy(busy24), .Err(err24)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ack16) begin
         if (q16.size() == 0) begin
            chk("spurious_ack16", 64'(ack16), 64'd0);
         end else begin
            exp_t e;
            e = q16.pop_front();
            chk("res16", 64'(res16), e.res);
            chk("err16", 64'(err16), 64'(e.err));
            chk("lat16", 64'(cyc - e.k + 1), 64'(e.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (ack24) begin
         if (q24.size() == 0) begin
            chk("spurious_ack24", 64'(ack24), 64'd0);
         end else begin
            exp_t e;
            e = q24.pop_front();
            chk("res24", 64'(res24), e.res);
            chk("err24", 64'(err24), 64'(e.err));
            chk("lat24", 64'(cyc - e.k + 1), 64'(e.lat));
         end
      end
   end

   task automatic wait_idle16();
      int n;
      n = 0;
      @(negedge clk);
      while (busy16 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("idle_timeout16", 64'(busy16), 64'd0);
   endtask

   task automatic issue16(input logic [1:0] m, input logic [15:0] a,
                          input logic [7:0] b, input logic [63:0] r,
                          input logic e, input int lat);
      wait_idle16();
      start16 = 1'b1;
      mode16  = m;
      opa16   = a;
      opb16   = b;
      q16.push_back('{res: r, err: e, lat: lat, k: cyc + 1});
      @(negedge clk);
      start16 = 1'b0;
      mode16  = ~m;
      opa16   = ~a;
      opb16   = ~b;
   endtask

   task automatic issue24(input logic [1:0] m, input logic [23:0] a,
                          input logic [11:0] b, input logic [63:0] r,
                          input int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (busy24 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("idle_timeout24", 64'(busy24), 64'd0);
      start24 = 1'b1;
      mode24  = m;
      opa24   = a;
      opb24   = b;
      q24.push_back('{res: r, err: 1'b0, lat: lat, k: cyc + 1});
      @(negedge clk);
      start24 = 1'b0;
      opa24   = ~a;
      opb24   = ~b;
   endtask

   function automatic void model24(input logic [1:0] m,
                                   input logic [23:0] a,
                                   input logic [11:0] b,
                                   output logic [63:0] r,
                                   output int lat);
      logic [63:0] qv, rr, t, rem, lim;
      r   = '0;
      lat = 0;
      if (m == 2'd0) begin
         lim = 64'hFF_FFFF;
         if (a == 0) begin
            r   = lim;
            lat = 1;
         end else begin
            qv  = (64'd1 << 24) / {40'd0, a};
            r   = (qv >> 1) + (qv & 64'd1);
            if (r > lim) r = lim;
            lat = 27;
         end
      end else if (m == 2'd1) begin
         lim = 64'hF_FFFF_FFFF;
         if (b == 0) begin
            r   = lim;
            lat = 1;
         end else begin
            qv  = ({40'd0, a} << 13) / {52'd0, b};
            r   = (qv >> 1) + (qv & 64'd1);
            if (r > lim) r = lim;
            lat = 39;
         end
      end else begin
         rr = '0;
         for (int i = 11; i >= 0; i--) begin
            t = rr | (64'd1 << i);
            if (t * t <= {40'd0, a}) rr = t;
         end
         rem = {40'd0, a} - rr * rr;
         r   = rr + ((rem > rr && rr != 64'd4095) ? 64'd1 : 64'd0);
         lat = 14;
      end
   endfunction

   task automatic seq16();
      int c;
      issue16(2'd0, 16'd4,      8'd0,   64'h2000,     1'b0, 19);
      issue16(2'd0, 16'd3,      8'd0,   64'h2AAB,     1'b0, 19);
      issue16(2'd0, 16'd1,      8'd0,   64'h8000,     1'b0, 19);
      issue16(2'd0, 16'd7,      8'd0,   64'h1249,     1'b0, 19);
      issue16(2'd0, 16'd0,      8'd0,   64'hFFFF,     1'b0, 1);
      issue16(2'd1, 16'd3,      8'hFF,  64'h000003,   1'b0, 27);
      issue16(2'd1, 16'hFFFF,   8'd1,   64'hFFFF00,   1'b0, 27);
      issue16(2'd1, 16'd1,      8'd3,   64'h000055,   1'b0, 27);
      issue16(2'd1, 16'd5,      8'd0,   64'hFFFFFF,   1'b0, 1);
      issue16(2'd2, 16'd81,     8'd0,   64'h09,       1'b0, 10);
      issue16(2'd2, 16'd90,     8'd0,   64'h09,       1'b0, 10);
      issue16(2'd2, 16'd91,     8'd0,   64'h0A,       1'b0, 10);
      issue16(2'd2, 16'hFFFF,   8'd0,   64'hFF,       1'b0, 10);
      issue16(2'd2, 16'd0,      8'd0,   64'h00,       1'b0, 10);
      issue16(2'd3, 16'h1234,   8'h56,  64'h0,        1'b1, 1);
      issue16(2'd0, 16'd2,      8'd0,   64'h4000,     1'b0, 19);

      // abort a DIV with reset: outputs clear, no Ack follows
      wait_idle16();
      start16 = 1'b1;
      mode16  = 2'd1;
      opa16   = 16'h1234;
      opb16   = 8'h12;
      @(negedge clk);
      start16 = 1'b0;
      repeat (5) @(negedge clk);
      rst16 = 1'b0;
      @(negedge clk);
      chk("rst_mid_result", 64'(res16), 64'd0);
      chk("rst_mid_ack",    64'(ack16), 64'd0);
      chk("rst_mid_busy",   64'(busy16), 64'd0);
      chk("rst_mid_err",    64'(err16), 64'd0);
      rst16 = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_mid_idle", 64'(busy16), 64'd0);

      // Start pulsed while busy is dropped
      issue16(2'd2, 16'd81, 8'd0, 64'h09, 1'b0, 10);
      repeat (2) @(negedge clk);
      start16 = 1'b1;
      mode16  = 2'd0;
      opa16   = 16'd4;
      @(negedge clk);
      start16 = 1'b0;

      // Start held through Ack: second op accepted at k+20
      wait_idle16();
      c       = cyc;
      start16 = 1'b1;
      mode16  = 2'd0;
      opa16   = 16'd3;
      q16.push_back('{res: 64'h2AAB, err: 1'b0, lat: 19, k: c + 1});
      q16.push_back('{res: 64'h2AAB, err: 1'b0, lat: 19, k: c + 21});
      repeat (21) @(negedge clk);
      start16 = 1'b0;
      wait_idle16();
   endtask

   task automatic seq24();
      logic [1:0]  m;
      logic [23:0] a;
      logic [11:0] b;
      logic [63:0] r;
      int          lat;
      for (int i = 0; i < 200; i++) begin
         m = 2'($urandom_range(0, 2));
         a = 24'($urandom);
         b = 12'($urandom);
         if ($urandom_range(0, 4) == 0) a = a >> $urandom_range(0, 23);
         if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(0, 11);
         if ($urandom_range(0, 19) == 0) begin
            a = '0;
            b = '0;
         end
         if (i == 0) begin
            m = 2'd2;
            a = 24'hFFFFFF;
         end
         model24(m, a, b, r, lat);
         issue24(m, a, b, r, lat);
      end
   endtask

   initial begin
      int n;
      cyc     = 0;
      total   = 0;
      bad     = 0;
      rst16   = 1'b0;
      start16 = 1'b0;
      mode16  = '0;
      opa16   = '0;
      opb16   = '0;
      rst24   = 1'b0;
      start24 = 1'b0;
      mode24  = '0;
      opa24   = '0;
      opb24   = '0;
      repeat (2) @(negedge clk);
      chk("reset_result16", 64'(res16), 64'd0);
      chk("reset_ack16",    64'(ack16), 64'd0);
      chk("reset_busy16",   64'(busy16), 64'd0);
      chk("reset_err16",    64'(err16), 64'd0);
      chk("reset_result24", 64'(res24), 64'd0);
      rst16 = 1'b1;
      rst24 = 1'b1;
      fork
         seq16();
         seq24();
      join
      n = 0;
      while ((q16.size() != 0 || q24.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain16", 64'(q16.size()), 64'd0);
      chk("drain24", 64'(q24.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
